// File: rtl/memory_adaptor.sv
// Byte-serialising arbiter between instruction fetch and load/store on the byte-wide RAM/IO bus.
// Reads capture one byte per cycle two edges behind the address; writes retry while the IO buffer is full.
module memory_adaptor #(
    parameter logic [31:0] IO_ADDR_MASK  = 32'h0003_0000,
    parameter bit          DATA_PRIORITY = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic        request_ins_from_memory_adaptor,
    input  logic [31:0] insaddr_to_be_fetched_from_memory_adaptor,
    output logic [31:0] ins_fetched_from_memory_adaptor,
    output logic        insfetch_task_done,
    input  logic        data_request,
    input  logic        data_is_write,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_task_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, IFETCH, DREAD, DWRITE} state_t;

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [2:0]  nbytes, nbytes_nx;
    logic [31:0] base_addr, base_addr_nx;
    logic [31:0] rbuf, rbuf_nx;
    logic [31:0] wbuf, wbuf_nx;
    logic        pend_valid, pend_valid_nx;
    logic [31:0] pend_addr, pend_addr_nx;
    logic [31:0] mem_a_nx;
    logic [7:0]  mem_dout_nx;
    logic [31:0] ins_word_nx, rdata_nx;
    logic        ins_done_nx, data_done_nx;

    logic [2:0]  size_n;
    logic [2:0]  cnt_inc;
    logic [1:0]  rbyte_idx, wbyte_idx;
    logic [31:0] merged;
    logic        io_hold;
    logic        data_ok, fetch_ok, take_data, take_fetch;

    assign io_hold   = ((mem_a & IO_ADDR_MASK) == IO_ADDR_MASK) && io_buffer_full;
    assign mem_wr    = (state == DWRITE) && rdy_in && !io_hold;
    assign cnt_inc   = cnt + 3'd1;
    // cnt runs one ahead of the byte being captured, so byte (cnt-1) lands on this edge
    assign rbyte_idx = cnt[1:0] - 2'd1;
    assign wbyte_idx = cnt[1:0] + 2'd1;
    assign size_n    = (data_size == 2'd0) ? 3'd1 : (data_size == 2'd1) ? 3'd2 : 3'd4;

    always_comb begin
        merged = rbuf;
        merged[{rbyte_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        nbytes_nx     = nbytes;
        base_addr_nx  = base_addr;
        rbuf_nx       = rbuf;
        wbuf_nx       = wbuf;
        pend_valid_nx = pend_valid;
        pend_addr_nx  = pend_addr;
        mem_a_nx      = mem_a;
        mem_dout_nx   = mem_dout;
        ins_word_nx   = ins_fetched_from_memory_adaptor;
        rdata_nx      = data_rdata;
        ins_done_nx   = 1'b0;
        data_done_nx  = 1'b0;

        // The completion cycle still sees data_request high; it must not restart the access.
        data_ok    = data_request && !data_task_done;
        fetch_ok   = pend_valid && !flush_pipline;
        take_data  = data_ok && (DATA_PRIORITY || !fetch_ok);
        take_fetch = fetch_ok && !take_data;

        if (flush_pipline) begin
            pend_valid_nx = 1'b0;
        end else if (request_ins_from_memory_adaptor) begin
            pend_valid_nx = 1'b1;
            pend_addr_nx  = insaddr_to_be_fetched_from_memory_adaptor;
        end

        case (state)
            IDLE: begin
                if (take_data) begin
                    base_addr_nx = data_addr;
                    mem_a_nx     = data_addr;
                    cnt_nx       = 3'd0;
                    nbytes_nx    = size_n;
                    rbuf_nx      = 32'd0;
                    if (data_is_write) begin
                        state_nx    = DWRITE;
                        wbuf_nx     = data_wdata;
                        mem_dout_nx = data_wdata[7:0];
                    end else begin
                        state_nx = DREAD;
                    end
                end else if (take_fetch) begin
                    state_nx      = IFETCH;
                    base_addr_nx  = pend_addr;
                    mem_a_nx      = pend_addr;
                    cnt_nx        = 3'd0;
                    nbytes_nx     = 3'd4;
                    rbuf_nx       = 32'd0;
                    pend_valid_nx = request_ins_from_memory_adaptor;
                end
            end
            IFETCH, DREAD: begin
                if (state == IFETCH && flush_pipline) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc < nbytes)
                        mem_a_nx = base_addr + {29'd0, cnt_inc};
                    if (cnt != 3'd0)
                        rbuf_nx = merged;
                    if (cnt == nbytes) begin
                        state_nx = IDLE;
                        if (state == IFETCH) begin
                            ins_word_nx = merged;
                            ins_done_nx = 1'b1;
                        end else begin
                            rdata_nx     = merged;
                            data_done_nx = 1'b1;
                        end
                    end
                end
            end
            DWRITE: begin
                if (mem_wr) begin
                    if (cnt == nbytes - 3'd1) begin
                        state_nx     = IDLE;
                        data_done_nx = 1'b1;
                    end else begin
                        cnt_nx      = cnt_inc;
                        mem_a_nx    = base_addr + {29'd0, cnt_inc};
                        mem_dout_nx = wbuf[{wbyte_idx, 3'b000} +: 8];
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state                           <= IDLE;
            cnt                             <= 3'd0;
            nbytes                          <= 3'd0;
            base_addr                       <= 32'd0;
            rbuf                            <= 32'd0;
            wbuf                            <= 32'd0;
            pend_valid                      <= 1'b0;
            pend_addr                       <= 32'd0;
            mem_a                           <= 32'd0;
            mem_dout                        <= 8'd0;
            ins_fetched_from_memory_adaptor <= 32'd0;
            insfetch_task_done              <= 1'b0;
            data_rdata                      <= 32'd0;
            data_task_done                  <= 1'b0;
        end else if (rdy_in) begin
            state                           <= state_nx;
            cnt                             <= cnt_nx;
            nbytes                          <= nbytes_nx;
            base_addr                       <= base_addr_nx;
            rbuf                            <= rbuf_nx;
            wbuf                            <= wbuf_nx;
            pend_valid                      <= pend_valid_nx;
            pend_addr                       <= pend_addr_nx;
            mem_a                           <= mem_a_nx;
            mem_dout                        <= mem_dout_nx;
            ins_fetched_from_memory_adaptor <= ins_word_nx;
            insfetch_task_done              <= ins_done_nx;
            data_rdata                      <= rdata_nx;
            data_task_done                  <= data_done_nx;
        end
    end

endmodule
